// File: rtl/rr_arb_pkg.sv
// Shared types, defaults and the token rotate helper for the round-robin arbiter.
package rr_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam int DEF_N        = 4;
   localparam int DEF_MAX_HOLD = 8;
   localparam int MAX_N        = 8;

   // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
   function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
      logic [MAX_N-1:0] mask;
      mask = ~(8'hFF << n);
      return ((v << 1) | (v >> (n - 1))) & mask;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above the token,
// wrapping past N-1. The request vector is doubled so the wrap becomes a
// plain lowest-set-bit search.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    token,
   output logic [N-1:0]    pick_onehot,
   output logic [ID_W-1:0] pick_id,
   output logic            any
);

   logic [2*N-1:0] w_dbl;

   // Lower copy only keeps bits at or above the token; upper copy covers the wrap.
   assign w_dbl = {req, req & ~(token - N'(1))};
   assign any   = |req;

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      pick_id = '0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (w_dbl[i]) begin
            if (i >= N) pick_id = ID_W'(i - N);
            else        pick_id = ID_W'(i);
         end
      end
      pick_onehot = any ? (N'(1) << pick_id) : '0;
   end

endmodule

// File: rtl/rr_token_arbiter.sv
// Round-robin arbiter: a one-hot ring token sets priority, a grant is held
// until done, request drop, or the hold limit; every grant ends with one
// IDLE cycle before the next one can be issued.
// Handshake: req is level-sensitive; a requester owns the resource for every
// cycle its gnt bit is high and gives it back by asserting done for one cycle
// or by dropping req; done outside a grant is ignored.
module rr_token_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int ID_W     = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            done,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [ID_W-1:0] gnt_id,
   output logic [N-1:0]    token,
   output logic            timeout,
   output logic            o_dbg_state
);

   localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

   arb_state_e      r_state;
   logic [N-1:0]    r_token;
   logic [N-1:0]    r_gnt;
   logic            r_gnt_valid;
   logic [ID_W-1:0] r_gnt_id;
   logic            r_timeout;
   logic [HC_W-1:0] r_hold_cnt;

   logic [N-1:0]     w_pick_oh;
   logic [ID_W-1:0]  w_pick_id;
   logic             w_any;
   logic             w_own_req;
   logic             w_hold_lim;
   logic             w_release;
   logic             w_timeout_only;
   logic [MAX_N-1:0] w_rot8;
   logic [N-1:0]     w_token_next;

   rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
      .req         (req),
      .token       (r_token),
      .pick_onehot (w_pick_oh),
      .pick_id     (w_pick_id),
      .any         (w_any)
   );

   // Release conditions for the current owner; timeout only when the limit alone forced it.
   assign w_own_req      = |(req & r_gnt);
   assign w_hold_lim     = (MAX_HOLD != 0) && (r_hold_cnt == HC_W'(MAX_HOLD));
   assign w_release      = done || !w_own_req || w_hold_lim;
   assign w_timeout_only = w_hold_lim && !done && w_own_req;
   assign w_rot8         = rotl1(MAX_N'(r_gnt), N);
   assign w_token_next   = w_rot8[N-1:0];

   // Arbiter FSM, token ring, hold counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_token     <= N'(1);
         r_gnt       <= '0;
         r_gnt_valid <= 1'b0;
         r_gnt_id    <= '0;
         r_timeout   <= 1'b0;
         r_hold_cnt  <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt       <= w_pick_oh;
                  r_gnt_valid <= 1'b1;
                  r_gnt_id    <= w_pick_id;
                  r_hold_cnt  <= HC_W'(1);
                  r_state     <= BUSY;
               end
            end
            BUSY: begin
               if (w_release) begin
                  r_gnt       <= '0;
                  r_gnt_valid <= 1'b0;
                  r_gnt_id    <= '0;
                  r_token     <= w_token_next;
                  r_timeout   <= w_timeout_only;
                  r_state     <= IDLE;
               end else if (r_hold_cnt != '1) begin
                  // Saturate so an unlimited hold never wraps the counter.
                  r_hold_cnt <= r_hold_cnt + HC_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign gnt_valid   = r_gnt_valid;
   assign gnt_id      = r_gnt_id;
   assign token       = r_token;
   assign timeout     = r_timeout;
   assign o_dbg_state = r_state;

endmodule
